// File: rtl/ktbs_cmd_pkg.sv
// Shared definitions for the KTBS command controller: ASCII opcodes, report tag,
// controller state encoding and an opcode classifier used for index validation.
package ktbs_cmd_pkg;

    localparam logic [7:0] OP_G_ON      = 8'h31;  // "1"
    localparam logic [7:0] OP_G_OFF     = 8'h32;  // "2"
    localparam logic [7:0] OP_R_ON      = 8'h33;  // "3"
    localparam logic [7:0] OP_R_OFF     = 8'h34;  // "4"
    localparam logic [7:0] OP_ADC_SEL   = 8'h35;  // "5"
    localparam logic [7:0] OP_ADC_DESEL = 8'h36;  // "6"
    localparam logic [7:0] OP_ADC_ALL   = 8'h37;  // "7"
    localparam logic [7:0] OP_RST_ALL   = 8'h38;  // "8"
    localparam logic [7:0] OP_G_TGL     = 8'h39;  // "9"
    localparam logic [7:0] OP_R_TGL     = 8'h41;  // "A"
    localparam logic [7:0] OP_BLINK_SET = 8'h42;  // "B"
    localparam logic [7:0] OP_BLINK_CLR = 8'h43;  // "C"
    localparam logic [7:0] OP_REPORT    = 8'h52;  // "R"

    localparam logic [7:0] RPT_TAG = 8'h52;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    // Which parameter bound the index of an opcode is checked against.
    typedef enum logic [1:0] {
        CLS_BAD = 2'd0,
        CLS_LED = 2'd1,
        CLS_ADC = 2'd2,
        CLS_ANY = 2'd3
    } op_class_t;

    function automatic op_class_t op_class(input logic [7:0] op);
        case (op)
            OP_G_ON, OP_G_OFF, OP_R_ON, OP_R_OFF, OP_G_TGL, OP_R_TGL,
            OP_BLINK_SET, OP_BLINK_CLR, OP_REPORT: return CLS_LED;
            OP_ADC_SEL, OP_ADC_DESEL:              return CLS_ADC;
            OP_ADC_ALL, OP_RST_ALL:                return CLS_ANY;
            default:                               return CLS_BAD;
        endcase
    endfunction

endpackage

// File: rtl/ktbs_cmd_if.sv
// Command and report channels between the SPI front end (master) and the controller (slave).
// Both channels: a word transfers on a rising edge where valid & ready are both high;
// the source holds valid and data stable until that transfer, and ready never waits on valid.
interface ktbs_cmd_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        rpt_valid;
    logic        rpt_ready;
    logic [15:0] rpt_data;

    modport master (
        output cmd_valid, cmd_data, rpt_ready,
        input  cmd_ready, rpt_valid, rpt_data
    );

    modport slave (
        input  cmd_valid, cmd_data, rpt_ready,
        output cmd_ready, rpt_valid, rpt_data
    );
endinterface

// File: rtl/ktbs_cmd_fifo.sv
// Synchronous FIFO for command words; DEPTH must be a power of two so the
// pointers wrap naturally. Push is ignored when full, pop ignored when empty.
module ktbs_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ktbs_cmd_ctrl.sv
// KTBS command controller: queued LED/ADC commands executed one at a time
// (IDLE -> EXEC -> optional RPT), with a blink overlay and a rejected-command counter.
module ktbs_cmd_ctrl
    import ktbs_cmd_pkg::*;
#(
    parameter int NLED       = 35,
    parameter int NADC       = 18,
    parameter int FIFO_DEPTH = 4,
    parameter int BLINK_DIV  = 24
) (
    input  logic            clk,
    input  logic            rst,
    ktbs_cmd_if.slave       bus,
    input  logic            en,
    output logic [NLED-1:0] gleds,
    output logic [NLED-1:0] rleds,
    output logic [NADC-1:0] adc_ncs,
    output logic [7:0]      err_cnt,
    output state_t          dbg_state
);
    state_t                 state_q, state_nx;
    logic                   fifo_full, fifo_empty, fifo_pop, do_exec;
    logic [15:0]            fifo_head, cmd_q, rpt_q, rpt_nx;
    logic [7:0]             op, idx;
    logic                   led_ok, adc_ok, cmd_ok;
    logic [NLED-1:0]        g_q, r_q, m_q, g_nx, r_nx, m_nx;
    logic [NLED-1:0]        led_bit, g_sh, r_sh, m_sh;
    logic [NADC-1:0]        adc_bit, ncs_nx;
    logic [7:0]             err_nx;
    logic [BLINK_DIV-1:0]   pre_q, pre_nx;

    assign bus.cmd_ready = !fifo_full && !rst;
    assign bus.rpt_valid = (state_q == ST_RPT);
    assign bus.rpt_data  = rpt_q;
    assign dbg_state     = state_q;

    ktbs_cmd_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .wdata (bus.cmd_data),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign op      = cmd_q[15:8];
    assign idx     = cmd_q[7:0];
    assign led_ok  = ({1'b0, idx} < 9'(NLED));
    assign adc_ok  = ({1'b0, idx} < 9'(NADC));
    assign led_bit = NLED'(1) << idx;
    assign adc_bit = NADC'(1) << idx;
    assign g_sh    = g_q >> idx;
    assign r_sh    = r_q >> idx;
    assign m_sh    = m_q >> idx;

    always_comb begin
        cmd_ok = 1'b0;
        case (op_class(op))
            CLS_LED: cmd_ok = led_ok;
            CLS_ADC: cmd_ok = adc_ok;
            CLS_ANY: cmd_ok = 1'b1;
            default: cmd_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        fifo_pop = 1'b0;
        do_exec  = 1'b0;
        case (state_q)
            ST_IDLE: if (!fifo_empty && en) begin
                fifo_pop = 1'b1;
                state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                do_exec  = 1'b1;
                state_nx = (cmd_ok && op == OP_REPORT) ? ST_RPT : ST_IDLE;
            end
            ST_RPT:  if (bus.rpt_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values of all architectural registers; a rejected command only bumps err_cnt.
    always_comb begin
        g_nx   = g_q;
        r_nx   = r_q;
        m_nx   = m_q;
        ncs_nx = adc_ncs;
        err_nx = err_cnt;
        rpt_nx = rpt_q;
        pre_nx = pre_q + BLINK_DIV'(1);
        if (do_exec) begin
            if (!cmd_ok) begin
                err_nx = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
            end else begin
                case (op)
                    OP_G_ON:      g_nx = g_q | led_bit;
                    OP_G_OFF:     g_nx = g_q & ~led_bit;
                    OP_R_ON:      r_nx = r_q | led_bit;
                    OP_R_OFF:     r_nx = r_q & ~led_bit;
                    OP_G_TGL:     g_nx = g_q ^ led_bit;
                    OP_R_TGL:     r_nx = r_q ^ led_bit;
                    OP_BLINK_SET: m_nx = m_q | led_bit;
                    OP_BLINK_CLR: m_nx = m_q & ~led_bit;
                    OP_ADC_SEL:   ncs_nx = ~adc_bit;
                    OP_ADC_DESEL: ncs_nx = adc_ncs | adc_bit;
                    OP_ADC_ALL:   ncs_nx = '1;
                    OP_RST_ALL: begin
                        ncs_nx = '1;
                        g_nx   = '0;
                        r_nx   = '0;
                        m_nx   = '0;
                    end
                    OP_REPORT:    rpt_nx = {RPT_TAG, 5'b0, m_sh[0], r_sh[0], g_sh[0]};
                    default:      ;
                endcase
            end
        end
    end

    // LED outputs are registered from next-state values so they move on the execute edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q   <= '0;
            g_q     <= '0;
            r_q     <= '0;
            m_q     <= '0;
            adc_ncs <= '1;
            err_cnt <= '0;
            rpt_q   <= '0;
            pre_q   <= '0;
            gleds   <= '0;
            rleds   <= '0;
        end else begin
            if (fifo_pop) cmd_q <= fifo_head;
            g_q     <= g_nx;
            r_q     <= r_nx;
            m_q     <= m_nx;
            adc_ncs <= ncs_nx;
            err_cnt <= err_nx;
            rpt_q   <= rpt_nx;
            pre_q   <= pre_nx;
            gleds   <= g_nx & ~(m_nx & {NLED{~pre_nx[BLINK_DIV-1]}});
            rleds   <= r_nx & ~(m_nx & {NLED{~pre_nx[BLINK_DIV-1]}});
        end
    end
endmodule

// File: tb/tb_ktbs_cmd_ctrl.sv
// Self-checking bench for ktbs_cmd_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a queue-based command model.
module tb_ktbs_cmd_ctrl;
    import ktbs_cmd_pkg::*;

    localparam int NLED  = 35;
    localparam int NADC  = 18;
    localparam int DEPTH = 4;
    localparam int BD    = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NLED-1:0] gleds, rleds;
    logic [NADC-1:0] adc_ncs;
    logic [7:0]      err_cnt;
    state_t          dbg_state;

    logic rand_mode = 1'b0;
    logic en_dir = 1'b1, rdy_dir = 1'b1, en_rnd = 1'b1, rdy_rnd = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    ktbs_cmd_if bus();

    assign en            = rand_mode ? en_rnd  : en_dir;
    assign bus.rpt_ready = rand_mode ? rdy_rnd : rdy_dir;

    ktbs_cmd_ctrl #(.NLED(NLED), .NADC(NADC), .FIFO_DEPTH(DEPTH), .BLINK_DIV(BD)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .en        (en),
        .gleds     (gleds),
        .rleds     (rleds),
        .adc_ncs   (adc_ncs),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        en_rnd  = ($urandom_range(0, 3) != 0);
        rdy_rnd = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endfunction

    // ---------------- behavioural model ----------------
    logic [15:0]     m_fifo[$];
    logic [NLED-1:0] m_g, m_r, m_b;
    logic [NADC-1:0] m_ncs;
    int              m_err;
    logic [15:0]     m_rpt, m_cur;
    bit              m_busy, m_rpt_pend, m_live = 1'b0, m_push, m_ph;
    int              m_cyc;
    logic [NLED-1:0] exp_g, exp_r;

    function automatic void m_exec(input logic [15:0] c);
        logic [7:0] op;
        int         ix;
        bit         ok;
        op = c[15:8];
        ix = int'(c[7:0]);
        case (op)
            "1", "2", "3", "4", "9", "A", "B", "C", "R": ok = (ix < NLED);
            "5", "6": ok = (ix < NADC);
            "7", "8": ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        if (!ok) begin
            if (m_err < 255) m_err++;
            return;
        end
        case (op)
            "1": m_g[ix] = 1'b1;
            "2": m_g[ix] = 1'b0;
            "3": m_r[ix] = 1'b1;
            "4": m_r[ix] = 1'b0;
            "9": m_g[ix] = ~m_g[ix];
            "A": m_r[ix] = ~m_r[ix];
            "B": m_b[ix] = 1'b1;
            "C": m_b[ix] = 1'b0;
            "5": begin m_ncs = '1; m_ncs[ix] = 1'b0; end
            "6": m_ncs[ix] = 1'b1;
            "7": m_ncs = '1;
            "8": begin m_ncs = '1; m_g = '0; m_r = '0; m_b = '0; end
            "R": begin m_rpt = {8'h52, 5'b0, m_b[ix], m_r[ix], m_g[ix]}; m_rpt_pend = 1'b1; end
            default: ;
        endcase
    endfunction

    // One command is taken from the queue when idle, takes effect one edge later,
    // and a report then blocks further commands until it is accepted.
    always @(posedge clk) begin
        if (rst) begin
            m_fifo.delete();
            m_g = '0; m_r = '0; m_b = '0; m_ncs = '1; m_err = 0; m_rpt = '0;
            m_busy = 1'b0; m_rpt_pend = 1'b0; m_cyc = 0; m_live = 1'b1;
        end else begin
            m_push = bus.cmd_valid && (m_fifo.size() < DEPTH);
            if (m_busy) begin
                m_exec(m_cur);
                m_busy = 1'b0;
            end else if (m_rpt_pend) begin
                if (bus.rpt_ready) m_rpt_pend = 1'b0;
            end else if (en && m_fifo.size() > 0) begin
                m_cur  = m_fifo.pop_front();
                m_busy = 1'b1;
            end
            if (m_push) m_fifo.push_back(bus.cmd_data);
            m_cyc++;
        end
    end

    // Compare process: every cycle, shortly after the active edge.
    always @(posedge clk) begin
        #2;
        if (m_live) begin
            m_ph  = ((m_cyc >> (BD - 1)) & 1) != 0;
            exp_g = m_ph ? m_g : (m_g & ~m_b);
            exp_r = m_ph ? m_r : (m_r & ~m_b);
            chk("gleds", 64'(gleds), 64'(exp_g));
            chk("rleds", 64'(rleds), 64'(exp_r));
            chk("adc_ncs", 64'(adc_ncs), 64'(m_ncs));
            chk("err_cnt", 64'(err_cnt), 64'(m_err));
            chk("rpt_valid", 64'(bus.rpt_valid), 64'(m_rpt_pend));
            chk("rpt_data", 64'(bus.rpt_data), 64'(m_rpt));
            chk("cmd_ready", 64'(bus.cmd_ready), 64'(!rst && (m_fifo.size() < DEPTH)));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] op, input logic [7:0] idx);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {op, idx};
        while (!bus.cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) timeout("push");
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((m_fifo.size() > 0 || m_busy || m_rpt_pend) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (m_fifo.size() > 0 || m_busy || m_rpt_pend) timeout("drain");
        @(negedge clk);
    endtask

    task automatic wait_rpt();
        int n;
        n = 0;
        while (!bus.rpt_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rpt_valid) timeout("wait_rpt");
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] op_tab [16];
    int         ones;
    logic       g_bit;

    initial begin
        op_tab = '{"1", "2", "3", "4", "5", "6", "7", "8",
                   "9", "A", "B", "C", "R", "R", "Z", 8'h00};
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_gleds", 64'(gleds), 64'h0);
        chk("rst_adc", 64'(adc_ncs), 64'h3FFFF);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'h0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Green then red on LED 3: two-edge latency, one command every two edges.
        push("1", 8'd3);
        push("3", 8'd3);
        chk("lat_n1_g", 64'(gleds), 64'h0);
        @(negedge clk);
        chk("lat_n2_g", 64'(gleds), 64'h8);
        chk("lat_n2_r", 64'(rleds), 64'h0);
        @(negedge clk);
        chk("lat_n3_r", 64'(rleds), 64'h0);
        @(negedge clk);
        chk("lat_n4_r", 64'(rleds), 64'h8);
        drain();

        // Exclusive ADC select, top index, deselect all.
        push("5", 8'd2);  drain(); chk("adc_sel2", 64'(adc_ncs), 64'h3FFFB);
        push("5", 8'd17); drain(); chk("adc_sel17", 64'(adc_ncs), 64'h1FFFF);
        push("7", 8'd0);  drain(); chk("adc_all", 64'(adc_ncs), 64'h3FFFF);

        // Queue fills while disabled, then drains in order.
        en_dir = 1'b0;
        @(negedge clk);
        push("1", 8'd0); push("1", 8'd1); push("1", 8'd2); push("3", 8'd0);
        chk("full_ready", 64'(bus.cmd_ready), 64'h0);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = {8'h33, 8'd1};
        repeat (3) @(negedge clk);
        chk("full_hold_ready", 64'(bus.cmd_ready), 64'h0);
        chk("disabled_gleds", 64'(gleds), 64'h8);
        en_dir = 1'b1;
        push("3", 8'd1);
        drain();
        chk("queued_gleds", 64'(gleds), 64'hF);
        chk("queued_rleds", 64'(rleds), 64'hB);

        // Report holds while not accepted and blocks the next command.
        push("8", 8'd0);
        push("1", 8'd3);
        rdy_dir = 1'b0;
        push("R", 8'd3);
        push("2", 8'd3);
        wait_rpt();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            g_bit = gleds[3];
            chk("rpt_hold_data", 64'(bus.rpt_data), 64'h5201);
            chk("rpt_hold_g3", 64'(g_bit), 64'h1);
        end
        rdy_dir = 1'b1;
        drain();
        chk("after_rpt_gleds", 64'(gleds), 64'h0);

        // Blink overlay: with a 4-bit prescaler the LED is on 8 of every 16 cycles.
        push("1", 8'd0);
        push("B", 8'd0);
        drain();
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (gleds[0]) ones++;
        end
        chk("blink_on_count", 64'(ones), 64'd8);

        // Reset while a report is pending.
        rdy_dir = 1'b0;
        push("R", 8'd0);
        wait_rpt();
        chk("rpt_blink_word", 64'(bus.rpt_data), 64'h5205);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_gleds", 64'(gleds), 64'h0);
        chk("mid_rst_rleds", 64'(rleds), 64'h0);
        chk("mid_rst_adc", 64'(adc_ncs), 64'h3FFFF);
        chk("mid_rst_rpt_valid", 64'(bus.rpt_valid), 64'h0);
        chk("mid_rst_rpt_data", 64'(bus.rpt_data), 64'h0);
        chk("mid_rst_ready", 64'(bus.cmd_ready), 64'h0);
        rst = 1'b0;
        rdy_dir = 1'b1;
        @(negedge clk);

        // Rejects: out-of-range LED, unknown opcode, out-of-range ADC; then saturation.
        push("1", 8'd35);
        push("Z", 8'd0);
        push("5", 8'd18);
        drain();
        chk("err_three", 64'(err_cnt), 64'd3);
        chk("err_gleds", 64'(gleds), 64'h0);
        chk("err_adc", 64'(adc_ncs), 64'h3FFFF);
        for (int i = 0; i < 300; i++) push("Z", 8'($urandom_range(0, 255)));
        drain();
        chk("err_saturate", 64'(err_cnt), 64'd255);

        // Randomized traffic with random enable and report back-pressure.
        rand_mode = 1'b1;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 9) == 0)
                push(op_tab[$urandom_range(0, 15)], 8'($urandom_range(0, 255)));
            else
                push(op_tab[$urandom_range(0, 15)], 8'($urandom_range(0, 40)));
        end
        rand_mode = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
